// File: rtl/rcpu_mem_arbiter_if.sv
// rcpu_mem_arbiter_if: shared memory port between the arbiter (master) and the memory/bus decoder (slave).
interface rcpu_mem_arbiter_if #(parameter int N = 32, parameter int M = 16);
  logic [N-1:0] memAddr;
  logic [M-1:0] memWrite;
  logic [M-1:0] memRead;
  logic memRE;
  logic memWE;
  logic memReady;
  modport master (output memAddr, memWrite, memRE, memWE, input memRead, memReady);
  modport slave (input memAddr, memWrite, memRE, memWE, output memRead, memReady);
endinterface

// File: rtl/rcpu_mem_arbiter.sv
// rcpu_mem_arbiter: round-robin multi-master memory arbiter with per-port lock and wait-state timeout.
module rcpu_mem_arbiter #(
  parameter int NUM_PORTS = 4,
  parameter int N = 32,
  parameter int M = 16,
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic [NUM_PORTS-1:0] port_re,
  input  logic [NUM_PORTS-1:0] port_we,
  input  logic [NUM_PORTS-1:0] port_lock,
  input  logic [NUM_PORTS*N-1:0] port_addr,
  input  logic [NUM_PORTS*M-1:0] port_wdata,
  output logic [M-1:0] port_rdata,
  output logic [NUM_PORTS-1:0] port_ready,
  output logic [NUM_PORTS-1:0] port_err,
  output logic [NUM_PORTS-1:0] port_grant,
  output logic busy,
  rcpu_mem_arbiter_if.master mem
);
  localparam int PW = $clog2(NUM_PORTS);
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic {IDLE, ACTIVE} state_t;
  state_t state;
  logic [PW-1:0] rr_ptr, g, pick, g_next;
  logic [PW:0] s;
  logic [CW-1:0] cnt;
  logic [NUM_PORTS-1:0] req;
  logic act, req_g, done, tmo;
  assign req = port_re | port_we;
  assign act = state == ACTIVE;
  assign req_g = act & req[g];
  assign done = req_g & mem.memReady;
  assign tmo = req_g & ~mem.memReady & (cnt == CW'(TIMEOUT));
  assign g_next = (g == PW'(NUM_PORTS - 1)) ? '0 : g + 1'b1;
  assign busy = act;
  // Scan from the farthest offset down so the requester nearest rr_ptr wins.
  always_comb begin
    pick = rr_ptr;
    s = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      s = {1'b0, rr_ptr} + (PW+1)'(i);
      s = (s >= (PW+1)'(NUM_PORTS)) ? s - (PW+1)'(NUM_PORTS) : s;
      pick = req[s[PW-1:0]] ? s[PW-1:0] : pick;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      rr_ptr <= '0;
      g <= '0;
      port_grant <= '0;
      cnt <= '0;
    end else if (!act) begin
      if (|req) begin
        state <= ACTIVE;
        g <= pick;
        port_grant <= NUM_PORTS'(1) << pick;
        cnt <= '0;
      end
    end else if (done || tmo || (!req[g] && !port_lock[g])) begin
      cnt <= '0;
      if (tmo || !port_lock[g]) begin
        state <= IDLE;
        port_grant <= '0;
        rr_ptr <= g_next;
      end
    end else if (req[g]) begin
      cnt <= cnt + 1'b1;
    end
  end
  assign mem.memAddr = act ? port_addr[g*N +: N] : '0;
  assign mem.memWrite = act ? port_wdata[g*M +: M] : '0;
  assign mem.memWE = req_g & port_we[g];
  assign mem.memRE = req_g & port_re[g] & ~port_we[g];
  assign port_ready = done ? port_grant : '0;
  assign port_err = tmo ? port_grant : '0;
  assign port_rdata = (done & ~port_we[g]) ? mem.memRead : '0;
endmodule

// File: tb/tb_rcpu_mem_arbiter.sv
// tb_rcpu_mem_arbiter: directed scenarios for the arbiter, TIMEOUT=4, four ports.
module tb_rcpu_mem_arbiter;
  logic clk = 0;
  logic rst = 1;
  logic [3:0] re = 0, we = 0, lock = 0;
  logic [127:0] addr = 0;
  logic [63:0] wdata = 0;
  logic [15:0] rdata;
  logic [3:0] ready, err, grant;
  logic busy;
  logic [14:0] ctl, exp;
  int checks = 0, fails = 0;
  rcpu_mem_arbiter_if #(.N(32), .M(16)) mem();
  rcpu_mem_arbiter #(.NUM_PORTS(4), .N(32), .M(16), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .port_re(re), .port_we(we), .port_lock(lock),
    .port_addr(addr), .port_wdata(wdata), .port_rdata(rdata), .port_ready(ready),
    .port_err(err), .port_grant(grant), .busy(busy), .mem(mem)
  );
  assign ctl = {grant, ready, err, busy, mem.memRE, mem.memWE};
  always #5 clk = ~clk;

  task automatic test_reset();
    mem.memReady = 0;
    mem.memRead = 0;
    #1 rst = 0;
    #1;
    checks++; if (ctl !== 15'd0) begin fails++; $display("FAIL rst_ctl got %b want %b", ctl, 15'd0); end
    checks++; if ({rdata, mem.memAddr, mem.memWrite} !== 64'd0) begin fails++; $display("FAIL rst_bus got %h want 0", {rdata, mem.memAddr, mem.memWrite}); end
    re = 4'b1111;
    @(negedge clk); #1;
    checks++; if (ctl !== 15'd0) begin fails++; $display("FAIL rst_held got %b want %b", ctl, 15'd0); end
    @(negedge clk);
    re = 0;
    rst = 1;
  endtask

  task automatic test_read();
    @(negedge clk);
    re[1] = 1; addr[32 +: 32] = 32'h0000_1234; mem.memReady = 0; #1;
    checks++; if (ctl !== 15'd0) begin fails++; $display("FAIL rd_c0 ctl got %b want %b", ctl, 15'd0); end
    @(negedge clk); #1;
    exp = {4'b0010, 4'b0000, 4'b0000, 3'b110};
    checks++; if (ctl !== exp) begin fails++; $display("FAIL rd_c1 ctl got %b want %b", ctl, exp); end
    checks++; if (mem.memAddr !== 32'h0000_1234) begin fails++; $display("FAIL rd_addr got %h want 00001234", mem.memAddr); end
    @(negedge clk); #1;
    checks++; if (ctl !== exp) begin fails++; $display("FAIL rd_c2 ctl got %b want %b", ctl, exp); end
    @(negedge clk);
    mem.memReady = 1; mem.memRead = 16'hBEEF; #1;
    exp = {4'b0010, 4'b0010, 4'b0000, 3'b110};
    checks++; if (ctl !== exp) begin fails++; $display("FAIL rd_c3 ctl got %b want %b", ctl, exp); end
    checks++; if (rdata !== 16'hBEEF) begin fails++; $display("FAIL rd_data got %h want beef", rdata); end
    @(negedge clk);
    re = 0; mem.memReady = 0; #1;
    checks++; if (ctl !== 15'd0) begin fails++; $display("FAIL rd_c4 ctl got %b want %b", ctl, 15'd0); end
  endtask

  task automatic test_round_robin();
    int ks[3] = '{0, 2, 3};
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    rst = 1;
    we = 4'b1101; mem.memReady = 1;
    foreach (ks[i]) begin
      addr[ks[i]*32 +: 32] = 32'h100 * ks[i];
      wdata[ks[i]*16 +: 16] = 16'hA0A0 | 16'(ks[i] * 16'h0101);
    end
    #1;
    checks++; if (ctl !== 15'd0) begin fails++; $display("FAIL rr_c0 ctl got %b want %b", ctl, 15'd0); end
    foreach (ks[i]) begin
      @(negedge clk); #1;
      exp = {4'b1 << ks[i], 4'b1 << ks[i], 4'b0000, 3'b101};
      checks++; if (ctl !== exp) begin fails++; $display("FAIL rr_p%0d ctl got %b want %b", ks[i], ctl, exp); end
      checks++; if (mem.memWrite !== (16'hA0A0 | 16'(ks[i] * 16'h0101))) begin fails++; $display("FAIL rr_p%0d wdata got %h", ks[i], mem.memWrite); end
      checks++; if (mem.memAddr !== 32'h100 * ks[i]) begin fails++; $display("FAIL rr_p%0d addr got %h", ks[i], mem.memAddr); end
      @(negedge clk);
      we[ks[i]] = 0; #1;
      checks++; if (ctl !== 15'd0) begin fails++; $display("FAIL rr_gap%0d ctl got %b want %b", ks[i], ctl, 15'd0); end
    end
  endtask

  task automatic test_lock();
    @(negedge clk);
    re[3] = 1; lock[3] = 1; addr[96 +: 32] = 32'h300; mem.memReady = 1; mem.memRead = 16'h1111; #1;
    checks++; if (ctl !== 15'd0) begin fails++; $display("FAIL lk_c0 ctl got %b want %b", ctl, 15'd0); end
    exp = {4'b1000, 4'b1000, 4'b0000, 3'b110};
    @(negedge clk);
    re[0] = 1; #1;
    checks++; if (ctl !== exp) begin fails++; $display("FAIL lk_c1 ctl got %b want %b", ctl, exp); end
    checks++; if (rdata !== 16'h1111) begin fails++; $display("FAIL lk_d1 got %h want 1111", rdata); end
    @(negedge clk);
    addr[96 +: 32] = 32'h304; mem.memRead = 16'h2222; #1;
    checks++; if (ctl !== exp) begin fails++; $display("FAIL lk_c2 ctl got %b want %b", ctl, exp); end
    checks++; if ({mem.memAddr, rdata} !== {32'h304, 16'h2222}) begin fails++; $display("FAIL lk_d2 got %h/%h want 304/2222", mem.memAddr, rdata); end
    @(negedge clk);
    lock[3] = 0; mem.memRead = 16'h3333; #1;
    checks++; if (ctl !== exp) begin fails++; $display("FAIL lk_c3 ctl got %b want %b", ctl, exp); end
    @(negedge clk);
    re[3] = 0; #1;
    checks++; if (ctl !== 15'd0) begin fails++; $display("FAIL lk_bubble ctl got %b want %b", ctl, 15'd0); end
    @(negedge clk); #1;
    exp = {4'b0001, 4'b0001, 4'b0000, 3'b110};
    checks++; if (ctl !== exp) begin fails++; $display("FAIL lk_p0 ctl got %b want %b", ctl, exp); end
    @(negedge clk);
    re[0] = 0; #1;
    checks++; if (ctl !== 15'd0) begin fails++; $display("FAIL lk_end ctl got %b want %b", ctl, 15'd0); end
  endtask

  task automatic test_timeout();
    @(negedge clk);
    re[2] = 1; re[3] = 1; mem.memReady = 0; mem.memRead = 16'h7777; #1;
    checks++; if (ctl !== 15'd0) begin fails++; $display("FAIL to_c0 ctl got %b want %b", ctl, 15'd0); end
    exp = {4'b0100, 4'b0000, 4'b0000, 3'b110};
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk); #1;
      checks++; if (ctl !== exp) begin fails++; $display("FAIL to_wait%0d ctl got %b want %b", i, ctl, exp); end
    end
    @(negedge clk); #1;
    exp = {4'b0100, 4'b0000, 4'b0100, 3'b110};
    checks++; if (ctl !== exp) begin fails++; $display("FAIL to_err ctl got %b want %b", ctl, exp); end
    @(negedge clk); #1;
    checks++; if (ctl !== 15'd0) begin fails++; $display("FAIL to_drop ctl got %b want %b", ctl, 15'd0); end
    @(negedge clk);
    re[2] = 0; mem.memReady = 1; #1;
    exp = {4'b1000, 4'b1000, 4'b0000, 3'b110};
    checks++; if (ctl !== exp) begin fails++; $display("FAIL to_next ctl got %b want %b", ctl, exp); end
    checks++; if (rdata !== 16'h7777) begin fails++; $display("FAIL to_data got %h want 7777", rdata); end
    @(negedge clk);
    re[3] = 0; mem.memReady = 0; #1;
    checks++; if (ctl !== 15'd0) begin fails++; $display("FAIL to_end ctl got %b want %b", ctl, 15'd0); end
  endtask

  task automatic test_rw_conflict();
    @(negedge clk);
    re[0] = 1; we[0] = 1; addr[0 +: 32] = 32'h10; wdata[0 +: 16] = 16'h5A5A; mem.memRead = 16'hFFFF; #1;
    checks++; if (ctl !== 15'd0) begin fails++; $display("FAIL rw_c0 ctl got %b want %b", ctl, 15'd0); end
    @(negedge clk); #1;
    exp = {4'b0001, 4'b0000, 4'b0000, 3'b101};
    checks++; if (ctl !== exp) begin fails++; $display("FAIL rw_c1 ctl got %b want %b", ctl, exp); end
    checks++; if ({mem.memAddr, mem.memWrite} !== {32'h10, 16'h5A5A}) begin fails++; $display("FAIL rw_bus got %h/%h want 10/5a5a", mem.memAddr, mem.memWrite); end
    @(negedge clk);
    mem.memReady = 1; #1;
    exp = {4'b0001, 4'b0001, 4'b0000, 3'b101};
    checks++; if (ctl !== exp) begin fails++; $display("FAIL rw_c2 ctl got %b want %b", ctl, exp); end
    checks++; if (rdata !== 16'h0) begin fails++; $display("FAIL rw_rdata got %h want 0000", rdata); end
    @(negedge clk);
    re = 0; we = 0; mem.memReady = 0; #1;
    checks++; if (ctl !== 15'd0) begin fails++; $display("FAIL rw_end ctl got %b want %b", ctl, 15'd0); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    we[1] = 1; addr[32 +: 32] = 32'h40; wdata[16 +: 16] = 16'h1357; #1;
    exp = {4'b0010, 4'b0000, 4'b0000, 3'b101};
    @(negedge clk); #1;
    checks++; if (ctl !== exp) begin fails++; $display("FAIL rm_c1 ctl got %b want %b", ctl, exp); end
    @(negedge clk); #1;
    checks++; if (ctl !== exp) begin fails++; $display("FAIL rm_c2 ctl got %b want %b", ctl, exp); end
    #2 rst = 0;
    #1;
    checks++; if (ctl !== 15'd0) begin fails++; $display("FAIL rm_async ctl got %b want %b", ctl, 15'd0); end
    checks++; if (mem.memAddr !== 32'h0) begin fails++; $display("FAIL rm_addr got %h want 0", mem.memAddr); end
    @(negedge clk);
    re[0] = 1; rst = 1; #1;
    checks++; if (ctl !== 15'd0) begin fails++; $display("FAIL rm_idle ctl got %b want %b", ctl, 15'd0); end
    @(negedge clk); #1;
    exp = {4'b0001, 4'b0000, 4'b0000, 3'b110};
    checks++; if (ctl !== exp) begin fails++; $display("FAIL rm_first ctl got %b want %b", ctl, exp); end
    @(negedge clk);
    re = 0; we = 0;
  endtask

  initial begin
    test_reset();
    test_read();
    test_round_robin();
    test_lock();
    test_timeout();
    test_rw_conflict();
    test_reset_mid();
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/rcpu_mem_arbiter.md
Name: rcpu_mem_arbiter

Overview:
- Parametrised multi-master memory arbiter. Shares the single memory port (memAddr/memRead/memWrite/memRE/memWE/memReady) among NUM_PORTS requesters: the CPU core, DMA channels and debug.
- Round-robin fairness, per-port lock for atomic sequences, wait-state handshake, and a timeout that returns an error instead of stalling a master forever.
- Sits between the masters and the memory/bus decoder.

Parameters:
- NUM_PORTS, 4, number of masters (2..8); port 0 is index 0 of every packed bus.
- N, 32, address width.
- M, 16, data width.
- TIMEOUT, 255, max memReady wait cycles per transaction (1..65535).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-low reset.
- port_re  in  NUM_PORTS  per-port read request.
- port_we  in  NUM_PORTS  per-port write request.
- port_lock  in  NUM_PORTS  keep grant after completion.
- port_addr  in  NUM_PORTS*N  packed addresses.
- port_wdata  in  NUM_PORTS*M  packed write data.
- port_rdata  out  M  read data, shared by all ports.
- port_ready  out  NUM_PORTS  one-hot transaction-done strobe.
- port_err  out  NUM_PORTS  one-hot timeout strobe.
- port_grant  out  NUM_PORTS  one-hot current owner.
- memAddr  out  N  memory address.
- memWrite  out  M  memory write data.
- memRead  in  M  memory read data.
- memRE  out  1  memory read enable.
- memWE  out  1  memory write enable.
- memReady  in  1  memory ready.
- busy  out  1  arbiter in ACTIVE.

Behaviour:
- Reset (rst=0, async): state=IDLE, rr_ptr=0, port_grant=0, timeout counter=0. port_ready, port_err, memRE, memWE, memAddr, memWrite, busy all 0; port_rdata=0.
- A port requests when re|we is set. It holds addr, wdata, re and we stable until it sees ready or err.
- States:
  - IDLE: port_grant=0 and no memory enables. If any request is present, pick the first requester scanning rr_ptr, rr_ptr+1, … modulo NUM_PORTS. Register it in port_grant and go to ACTIVE.
  - ACTIVE: memAddr, memWrite, memRE and memWE mirror the granted port combinationally.
- Grant latency: request seen at edge t gives grant and memory enables during cycle t+1.
- Simultaneous re and we on one port: the write wins; memRE=0, memWE=1.
- Completion: in ACTIVE, request present and memReady=1 means a transfer this cycle.
  - port_ready[g]=1 for that cycle.
  - port_rdata=memRead on reads; port_rdata=0 otherwise.
  - Counter clears.
- After completion:
  - port_lock[g]=1: stay ACTIVE on g, so the next transfer from g has no bubble.
  - port_lock[g]=0: go IDLE and set rr_ptr=(g+1) mod NUM_PORTS. One idle bubble between owners.
- Wait states: request present and memReady=0 increments the counter.
- Timeout: when the counter reaches TIMEOUT with memReady still 0:
  - port_err[g]=1 for one cycle and port_ready[g]=0.
  - Memory enables drop the next cycle.
  - Go IDLE; rr_ptr=g+1; counter=0.
  - The lock is ignored on error.
- memReady=1 in the timeout cycle counts as completion, not error.
- Granted port drops its request while ACTIVE:
  - lock=0: release to IDLE the next edge.
  - lock=1: hold the grant with enables 0 until the request returns or lock drops.
  - The counter only counts while a request is present.
- memReady while IDLE or with no request present: ignored.
- Reset mid-transaction: all outputs clear immediately (async); no ready or err is issued for the aborted transfer.
- port_ready and port_err are never both set; each is at most one-hot.

Test Plan:
- Port 1 read at addr 0x00001234, memReady low for 2 cycles then high with memRead=0xBEEF -> grant at t+1; port_ready=4'b0010 at t+3; port_rdata=0xBEEF; busy drops at t+4.
- Ports 0, 2 and 3 all request writes at the same cycle from reset, memReady tied 1 -> grants in order 0, 2, 3; each completes in 1 cycle with a 1-cycle IDLE between; memWrite matches each port's wdata.
- Port 3 lock=1 for 3 back-to-back reads, port 0 requesting throughout -> port 3 keeps the grant for 3 consecutive ready cycles with no bubble; port 0 is granted after lock drops.
- TIMEOUT=4, port 2 read with memReady held 0 -> port_err=4'b0100 after 4 wait cycles, no ready; memRE=0 next cycle; port 3 is served next.
- Port 0 with re=we=1, addr 0x10, wdata 0x5A5A -> memWE=1, memRE=0, memWrite=0x5A5A.
- rst pulled low during a wait state of a port 1 write -> memWE, port_grant and busy go 0 without a clock edge; after release, port 0 requesting is granted first (rr_ptr=0).
